// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button conditioners: FSM state encodings,
// default 100 MHz timing constants and a small elaboration-time helper.
package button_conditioner_pkg;

  typedef enum logic [2:0] {
    BTN_IDLE         = 3'd0,
    BTN_PRESS_WAIT   = 3'd1,
    BTN_HELD         = 3'd2,
    BTN_LONG_HELD    = 3'd3,
    BTN_RELEASE_WAIT = 3'd4
  } btn_state_e;

  // 10 ms debounce, 1 s long press, 200 ms auto-repeat at 100 MHz
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd1_000_000;
  localparam int unsigned DEF_LONG_CYCLES     = 32'd100_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES   = 32'd20_000_000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs; both stages reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // metastability filter chain
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// Synchronizes and debounces one push button, producing a clean level plus
// single-cycle press, release, long-press and auto-repeat pulses.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = $clog2(max_u(LONG_CYCLES, REPEAT_CYCLES));
  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [HOLD_W-1:0] LONG_LAST   = HOLD_W'(LONG_CYCLES - 32'd1);
  localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYCLES - 32'd1);

  logic btn_sync;

  sync_2ff u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (btn_in),
    .q      (btn_sync)
  );

  btn_state_e        state_q,    state_d;
  logic [DB_W-1:0]   db_cnt_q,   db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic was_long_q,  was_long_d;
  logic level_q,     level_d;
  logic press_q,     press_d;
  logic release_q,   release_d;
  logic long_q,      long_d;
  logic repeat_q,    repeat_d;

  // next-state, counter and pulse decode
  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    was_long_d = was_long_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;
    case (state_q)
      BTN_IDLE: begin
        if (btn_sync) begin
          state_d  = BTN_PRESS_WAIT;
          db_cnt_d = '0;
        end else begin
          state_d = BTN_IDLE;
        end
      end
      BTN_PRESS_WAIT: begin
        if (!btn_sync) begin
          state_d = BTN_IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = BTN_HELD;
          hold_cnt_d = '0;
          press_d    = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      BTN_HELD: begin
        if (!btn_sync) begin
          state_d    = BTN_RELEASE_WAIT;
          db_cnt_d   = '0;
          was_long_d = 1'b0;
        end else if (hold_cnt_q == LONG_LAST) begin
          state_d    = BTN_LONG_HELD;
          hold_cnt_d = '0;
          long_d     = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      BTN_LONG_HELD: begin
        if (!btn_sync) begin
          state_d    = BTN_RELEASE_WAIT;
          db_cnt_d   = '0;
          was_long_d = 1'b1;
        end else if (hold_cnt_q == REPEAT_LAST) begin
          hold_cnt_d = '0;
          repeat_d   = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      BTN_RELEASE_WAIT: begin
        // hold_cnt stays frozen so a release glitch resumes the hold timing
        if (btn_sync) begin
          state_d = was_long_q ? BTN_LONG_HELD : BTN_HELD;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = BTN_IDLE;
          release_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      default: begin
        state_d    = BTN_IDLE;
        db_cnt_d   = '0;
        hold_cnt_d = '0;
        was_long_d = 1'b0;
      end
    endcase
    level_d = (state_d == BTN_HELD) || (state_d == BTN_LONG_HELD) ||
              (state_d == BTN_RELEASE_WAIT);
  end

  // state, counters and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= BTN_IDLE;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      was_long_q <= 1'b0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      was_long_q <= was_long_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized and directed bench for button_conditioner with a behavioural
// run-length model and literal timing expectations.
module tb_button_conditioner;

  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 5;

  logic clk;
  logic resetn;
  logic btn_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;
  logic repeat_pulse;

  button_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L),
    .REPEAT_CYCLES   (R)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .btn_in        (btn_in),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;

  // Model: the accepted level flips once the synchronized input has disagreed
  // with it for D+1 consecutive edges; hold time counts steady held edges only.
  bit m_hist[$];
  bit m_level, m_long_mode, m_press, m_rel, m_long, m_rep;
  int m_pend, m_hold;
  int outstanding, presses_seen;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    m_hist.push_back(1'b0);
    m_hist.push_back(1'b0);
    m_level = 1'b0; m_long_mode = 1'b0;
    m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0; m_rep = 1'b0;
    m_pend = 0; m_hold = 0;
    outstanding = 0;
  endtask

  task automatic model_step(input bit b);
    bit seen;
    seen = m_hist.pop_front();
    m_hist.push_back(b);
    m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0; m_rep = 1'b0;
    if (seen != m_level) begin
      m_pend++;
      if (m_pend == D + 1) begin
        m_level = seen;
        m_pend = 0;
        if (seen) begin
          m_press = 1'b1; m_hold = 0; m_long_mode = 1'b0;
        end else begin
          m_rel = 1'b1;
        end
      end
    end else begin
      if (m_level && m_pend == 0) begin
        m_hold++;
        if (!m_long_mode && m_hold == L) begin
          m_long = 1'b1; m_long_mode = 1'b1; m_hold = 0;
        end else if (m_long_mode && m_hold == R) begin
          m_rep = 1'b1; m_hold = 0;
        end
      end
      m_pend = 0;
    end
  endtask

  task automatic cycle(input bit b);
    btn_in = b;
    @(posedge clk);
    model_step(b);
    @(negedge clk);
  endtask

  // per-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk1("level", btn_level, m_level);
      chk1("press", press_pulse, m_press);
      chk1("release", release_pulse, m_rel);
      chk1("long", long_pulse, m_long);
      chk1("repeat", repeat_pulse, m_rep);
      chk1("exclusive", ($countones({press_pulse, release_pulse, long_pulse, repeat_pulse}) <= 1), 1'b1);
      if (press_pulse) begin
        chk_int("press_pairing", outstanding, 0);
        outstanding = 1;
        presses_seen++;
      end else if (release_pulse) begin
        chk_int("release_pairing", outstanding, 1);
        outstanding = 0;
      end
    end
  end

  bit rb;
  int rlen;
  int rcyc;

  initial begin
    resetn = 1'b0;
    btn_in = 1'b0;
    presses_seen = 0;
    model_reset();
    @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    chk1("reset_level", btn_level, 1'b0);
    chk1("reset_press", press_pulse, 1'b0);
    resetn = 1'b1;
    for (int k = 0; k < 12; k++) cycle(1'b0);

    // clean press then release
    for (int n = 0; n < 22; n++) begin
      cycle(n < 10);
      chk1("clean_press_edge", press_pulse, n == 6);
      chk1("clean_level", btn_level, (n >= 6 && n < 16));
      chk1("clean_release_edge", release_pulse, n == 16);
    end

    // bounce rejection
    for (int n = 0; n < 16; n++) begin
      cycle((n < 3) || (n == 5) || (n == 6));
      chk1("bounce_level", btn_level, 1'b0);
      chk1("bounce_press", press_pulse, 1'b0);
      chk1("bounce_release", release_pulse, 1'b0);
    end

    // long hold with auto-repeat
    for (int n = 0; n < 72; n++) begin
      cycle(n < 60);
      chk1("hold_press_edge", press_pulse, n == 6);
      chk1("hold_long_edge", long_pulse, n == 26);
      chk1("hold_repeat_edge", repeat_pulse, (n >= 31 && n <= 61 && (n - 31) % 5 == 0));
      chk1("hold_release_edge", release_pulse, n == 66);
    end

    // release glitch in HELD freezes hold timing for three edges
    for (int n = 0; n < 52; n++) begin
      cycle(!(n == 12 || n == 13) && (n < 40));
      chk1("glitch_press_edge", press_pulse, n == 6);
      chk1("glitch_long_edge", long_pulse, n == 29);
      chk1("glitch_repeat_edge", repeat_pulse, (n == 34 || n == 39));
      chk1("glitch_release_edge", release_pulse, n == 46);
      chk1("glitch_level", btn_level, (n >= 6 && n < 46));
    end

    // reset asserted during LONG_HELD, button kept down
    for (int n = 0; n < 30; n++) cycle(1'b1);
    chk1("pre_reset_level", btn_level, 1'b1);
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    chk1("async_rst_level", btn_level, 1'b0);
    chk1("async_rst_any_pulse", (press_pulse | release_pulse | long_pulse | repeat_pulse), 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int n = 0; n < 22; n++) begin
      cycle(n < 10);
      chk1("post_rst_press_edge", press_pulse, n == 6);
      chk1("post_rst_release_edge", release_pulse, n == 16);
    end

    // randomized runs of high/low levels
    rcyc = 0;
    while (rcyc < 10000) begin
      rb = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) rlen = int'($urandom_range(20, 60));
      else rlen = int'($urandom_range(1, 6));
      for (int k = 0; k < rlen; k++) cycle(rb);
      rcyc += rlen;
    end
    for (int k = 0; k < 14; k++) cycle(1'b0);
    chk_int("end_balanced", outstanding, 0);
    chk1("random_saw_presses", presses_seen > 10, 1'b1);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
